// File: rtl/counter_driver.sv
// Master-side driver for a step/overwrite counter: executes LOAD/RUN commands,
// holds the counter while idle, and checks the returned count against a shadow model.
module counter_driver #(
  parameter int unsigned WIDTH    = 8,
  parameter bit          CHECK_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             mode,
  output logic [WIDTH-1:0] write_data,
  input  logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] exp_count,
  output logic             mismatch,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_e;

  localparam logic [1:0] OP_LOAD    = 2'd0;
  localparam logic [1:0] OP_RUN     = 2'd1;
  localparam logic [1:0] OP_CLR_ERR = 2'd2;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             mis_q, mis_d;
  logic [7:0]       err_q, err_d;
  logic             accept;

  always_comb begin
    accept  = cmd_valid && (state_q == S_IDLE);
    // Shadow model follows exactly what is being driven to the counter this cycle.
    exp_d   = mode_q ? wdata_q : exp_q + WIDTH'(1);
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_LOAD: state_d = S_LOAD;
            OP_RUN: begin
              if (cmd_data != '0) begin
                state_d = S_RUN;
                rem_d   = cmd_data;
              end else begin
                done_d = 1'b1;
              end
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      S_LOAD: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      S_RUN: begin
        rem_d = rem_q - WIDTH'(1);
        if (rem_q == WIDTH'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Drive outputs are registered, so they are derived from the next state.
    mode_d  = (state_d != S_RUN);
    wdata_d = (state_d == S_LOAD) ? cmd_data : exp_d;

    mis_d = mis_q;
    err_d = err_q;
    if (CHECK_EN) begin
      if (count != exp_q) begin
        mis_d = 1'b1;
        if (err_q != 8'hFF) err_d = err_q + 8'd1;
      end
      if (accept && (cmd_op == OP_CLR_ERR)) begin
        mis_d = 1'b0;
        err_d = '0;
      end
    end else begin
      mis_d = 1'b0;
      err_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      exp_q   <= '0;
      wdata_q <= '0;
      mode_q  <= 1'b1;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      exp_q   <= exp_d;
      wdata_q <= wdata_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign mode       = mode_q;
  assign write_data = wdata_q;
  assign exp_count  = exp_q;
  assign mismatch   = mis_q;
  assign err_cnt    = err_q;

endmodule

// File: doc/counter_driver.md
Name: counter_driver

Overview:
- Master-side controller for the step/overwrite counter interface (mode, write_data, count).
- Accepts LOAD and RUN commands over a valid/ready handshake and translates them into cycle-accurate mode/write_data drive.
- Holds the counter frozen while idle, using overwrite-with-current-value.
- Keeps a shadow model of the expected count and compares it every cycle against the returned count, flagging divergence.

Parameters:
- WIDTH, 8, counter and data width.
- CHECK_EN, 1, enables the count-vs-model checker; when 0, mismatch and err_cnt stay 0.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset. Shared with the counter.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE.
- cmd_op  input  2  0=LOAD, 1=RUN, 2=CLR_ERR, 3=reserved.
- cmd_data  input  WIDTH  LOAD value, or RUN step count N.
- mode  output  1  to counter: 0=step (count+1), 1=overwrite (count<=write_data).
- write_data  output  WIDTH  to counter.
- count  input  WIDTH  from counter.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse when an op completes.
- exp_count  output  WIDTH  shadow model value.
- mismatch  output  1  sticky checker error.
- err_cnt  output  8  saturating count of mismatching cycles.

Behaviour:
- Counter model: on each clk edge, mode=0 gives count<=count+1 mod 2^WIDTH; mode=1 gives count<=write_data. rst clears count to 0.
- exp_count register: updated on every edge with exactly the same rule, using the mode/write_data driven that cycle. Invariant: exp_count==count in every cycle.
- States:
  - IDLE: mode=1, write_data=exp_count (hold); cmd_ready=1.
  - LOAD: mode=1, write_data=load_val; lasts 1 cycle.
  - RUN: mode=0, write_data=exp_count; lasts N cycles; a remaining-step register counts down.
- Accepting a command: a handshake (cmd_valid&&cmd_ready) in IDLE at cycle T latches cmd_data.
- LOAD: state is LOAD in T+1, then IDLE in T+2. At T+2, count==cmd_data and done=1.
- RUN, N>=1: state is RUN in T+1..T+N, then IDLE in T+N+1. At T+N+1, count==old+N mod 2^WIDTH and done=1.
- RUN, N=0: no step cycles. The FSM stays in IDLE (hold continues) and done=1 in T+1.
- CLR_ERR: clears mismatch and err_cnt on the accepting edge. done=1 in T+1. No counter effect.
- op 3: accepted and ignored; done=1 in T+1.
- done: registered; high exactly 1 cycle per accepted command. Its cycle is an IDLE cycle, so a new command can be accepted in that same cycle (back-to-back throughput = op length + 1 cycle).
- Wrap-around: RUN past 2^WIDTH-1 wraps to 0 in both the counter and the model; no flag.
- Checker (CHECK_EN=1): each edge while not in reset, if count!=exp_count, set mismatch (sticky) and increment err_cnt (saturates at 255).
  - If CLR_ERR is accepted in the same cycle as a mismatch, the clear wins.
  - The model is never resynced from count.
- Reset (asynchronous, any state including mid-RUN or mid-LOAD): state=IDLE, exp_count=0, remaining=0, done=0, mismatch=0, err_cnt=0. Hence mode=1, write_data=0, cmd_ready=1, busy=0.
- cmd_valid during busy: ignored (not accepted, no ready). The requester must hold it until ready.

Test Plan:
- Reset, then idle 10 cycles -> mode=1, write_data=0, count stays 0, done never pulses, mismatch=0.
- LOAD 8'hAA -> 1 busy cycle with mode=1, write_data=8'hAA. Next cycle: done=1, count=exp_count=8'hAA. Count stays 8'hAA for 5 further idle cycles.
- LOAD 8'hFE, then RUN 5 -> mode=0 for exactly 5 cycles. Then done=1 with count=8'h03 (wrap), mismatch=0.
- RUN 0 from count 8'h10 -> done=1 the next cycle, busy never high, count 8'h10. Then LOAD/RUN/LOAD back-to-back with cmd_valid held -> each accepted in its done cycle, results correct.
- Force count to 8'h55 for 2 cycles while exp_count=8'h10 -> mismatch=1, err_cnt=2, both sticky after release. CLR_ERR -> mismatch=0, err_cnt=0.
- Assert rst at cycle 3 of RUN 20 -> immediately IDLE, mode=1, write_data=0, busy=0, exp_count=0. Counter reset to 0, no mismatch after release.
